seg7_write_sched: RTL

- Schedules and sequences writes into the four-digit 7-segment display controller.
- Two requesters (A = CPU peripheral bus, B = debug/status source) each present a 16-bit hex value and a decimal-point digit index.
- A round-robin arbiter grants one requester. The block then issues four single-cycle digit writes (seg7_sel/addr/data_to_wr), ordered so that the dot-marked digit is written last.
- The display controller marks the last-written digit with the dot, so write order is how dot position is set.

---
 rtl/seg7_write_sched_pkg.sv | 32 +++
 rtl/seg7_rr_arb2.sv | 34 +++
 rtl/seg7_write_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg7_write_sched_pkg.sv
// Shared types, constants and digit-order helpers for the 7-segment write scheduler.
// Write ordering places the dot digit last, because the controller dots the last-written digit.
package seg7_write_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAPW  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned NDIG  = 4;
   localparam int unsigned NIB_W = 4;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   // First three writes cover the non-dot digits in ascending order, then the dot digit.
   function automatic logic [1:0] write_addr(input logic [1:0] dot, input logic [1:0] idx);
      if (idx == 2'(NDIG - 1))
         return dot;
      else if (idx >= dot)
         return idx + 2'd1;
      else
         return idx;
   endfunction

   function automatic logic [NIB_W-1:0] digit_nib(input logic [15:0] val, input logic [1:0] a);
      return val[a*NIB_W +: NIB_W];
   endfunction

endpackage

// File: rtl/seg7_rr_arb2.sv
// Two-input round-robin arbiter; the grant is combinational, last_grant updates when the grant is taken.
// After reset last_grant is B, so A wins the first tie.
module seg7_rr_arb2
   import seg7_write_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic advance,
   output logic grant_valid,
   output logic grant_id
);

   logic last_grant;

   always_comb begin
      grant_valid = req_a | req_b;
      if (req_a && req_b)
         grant_id = ~last_grant;
      else if (req_a)
         grant_id = REQ_A;
      else
         grant_id = REQ_B;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant <= REQ_B;
      else if (advance)
         last_grant <= grant_id;
   end

endmodule

// File: rtl/seg7_write_sched.sv
// Arbitrates two requesters and issues four digit writes to the 7-segment controller, dot digit last.
// All outputs are registered: each write's strobe/addr/data is loaded on the edge entering WRITE.
module seg7_write_sched
   import seg7_write_sched_pkg::*;
#(
   parameter int unsigned GAP = 0
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [15:0] val_a,
   input  logic [1:0]  dot_a,
   output logic        ack_a,
   input  logic        req_b,
   input  logic [15:0] val_b,
   input  logic [1:0]  dot_b,
   output logic        ack_b,
   output logic        busy,
   output logic        seg7_sel,
   output logic [1:0]  addr,
   output logic [3:0]  data_to_wr
);

   localparam logic [3:0] GAP_INIT = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   state_t      state;
   logic [15:0] val_reg;
   logic [1:0]  dot_reg;
   logic [1:0]  idx;
   logic [3:0]  gap_cnt;
   logic        gid;

   logic        grant_valid;
   logic        grant_id;
   logic        advance;
   logic [15:0] val_sel;
   logic [1:0]  dot_sel;
   logic [1:0]  first_addr;
   logic [1:0]  next_addr;
   logic        last_wr;

   assign advance = (state == IDLE) && grant_valid;

   seg7_rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_a       (req_a),
      .req_b       (req_b),
      .advance     (advance),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_comb begin
      val_sel    = (grant_id == REQ_A) ? val_a : val_b;
      dot_sel    = (grant_id == REQ_A) ? dot_a : dot_b;
      first_addr = write_addr(dot_sel, 2'd0);
      next_addr  = write_addr(dot_reg, idx + 2'd1);
      last_wr    = (idx == 2'(NDIG - 1));
   end

   // idx is the index of the write currently on the outputs, not the next one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         val_reg    <= '0;
         dot_reg    <= '0;
         idx        <= '0;
         gap_cnt    <= '0;
         gid        <= REQ_B;
         seg7_sel   <= 1'b0;
         addr       <= '0;
         data_to_wr <= '0;
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         seg7_sel <= 1'b0;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_valid) begin
                  state      <= WRITE;
                  gid        <= grant_id;
                  val_reg    <= val_sel;
                  dot_reg    <= dot_sel;
                  idx        <= '0;
                  seg7_sel   <= 1'b1;
                  addr       <= first_addr;
                  data_to_wr <= digit_nib(val_sel, first_addr);
                  busy       <= 1'b1;
               end
            end
            WRITE: begin
               if (GAP > 0) begin
                  state   <= GAPW;
                  gap_cnt <= GAP_INIT;
               end else if (last_wr) begin
                  state <= DONE;
                  ack_a <= (gid == REQ_A);
                  ack_b <= (gid == REQ_B);
               end else begin
                  idx        <= idx + 2'd1;
                  seg7_sel   <= 1'b1;
                  addr       <= next_addr;
                  data_to_wr <= digit_nib(val_reg, next_addr);
               end
            end
            GAPW: begin
               if (gap_cnt != 4'd0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else if (last_wr) begin
                  state <= DONE;
                  ack_a <= (gid == REQ_A);
                  ack_b <= (gid == REQ_B);
               end else begin
                  state      <= WRITE;
                  idx        <= idx + 2'd1;
                  seg7_sel   <= 1'b1;
                  addr       <= next_addr;
                  data_to_wr <= digit_nib(val_reg, next_addr);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
